// File: rtl/cpu_pv.sv
// Small multi-cycle accumulator-less CPU: eight registers (r7 = SP), vectored
// prioritized interrupts and a ready-stalled single-port memory interface.
module cpu_pv #(
  parameter int            DW       = 16,
  parameter int            AW       = 12,
  parameter int            NINT     = 4,
  parameter logic [AW-1:0] VEC_BASE = 'h7F0,
  parameter logic [AW-1:0] SP_INIT  = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   data_in,
  output logic [DW-1:0]   data_out,
  output logic [AW-1:0]   address,
  output logic            memwt,
  input  logic            mem_rdy,
  input  logic [NINT-1:0] INT,
  output logic [NINT-1:0] intack
);

  typedef enum logic [4:0] {
    S_FETCH, S_NOP, S_LDI, S_LD, S_ST, S_JZ, S_JMP, S_ALU,
    S_PUSH, S_POP1, S_POP2, S_CALL, S_RET1, S_RET2, S_STI, S_CLI,
    S_IRET1, S_IRET2, S_IRET3, S_INT1, S_INT2, S_INT3
  } state_t;

  localparam logic [DW-1:0] ONE_D = 1;
  localparam logic [AW-1:0] ONE_A = 1;

  state_t          state, state_nx, done_nx;
  logic [AW-1:0]   pc;
  logic [DW-5:0]   ir;
  logic [2:0]      chan, int_chan;
  logic            zf, ief;
  logic [DW-1:0]   regs [8];

  logic [3:0]      opcode;
  logic [2:0]      f_d, f_a, f_b, f_f;
  logic [DW-1:0]   a_val, b_val, sp, alu_res;

  assign opcode = data_in[DW-1:DW-4];
  assign f_d    = ir[2:0];
  assign f_a    = ir[5:3];
  assign f_b    = ir[8:6];
  assign f_f    = ir[11:9];
  assign a_val  = regs[f_a];
  assign b_val  = regs[f_b];
  assign sp     = regs[7];

  function automatic logic [DW-1:0] clz(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = DW'(DW);
    for (int i = 0; i < DW; i++)
      if (v[i]) r = DW'(DW - 1 - i);
    return r;
  endfunction

  always_comb begin
    alu_res = '0;
    case (f_f)
      3'd0: alu_res = b_val + a_val;
      3'd1: alu_res = a_val - b_val;
      3'd2: alu_res = b_val & a_val;
      3'd3: alu_res = b_val | a_val;
      3'd4: alu_res = b_val ^ a_val;
      3'd5: alu_res = a_val << b_val;
      3'd6: alu_res = a_val >> b_val;
      default: begin
        case (f_b)
          3'd0: alu_res = DW'(a_val == '0);
          3'd1: alu_res = a_val;
          3'd2: alu_res = a_val + ONE_D;
          3'd3: alu_res = a_val - ONE_D;
          3'd4: alu_res = clz(a_val);
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // Lowest index wins: scan high to low so the last hit is the smallest.
  always_comb begin
    int_chan = '0;
    for (int i = NINT - 1; i >= 0; i--)
      if (INT[i]) int_chan = 3'(i);
  end

  // Interrupt check uses the current ief, so an STI only takes effect one
  // instruction later.
  assign done_nx = (ief && (INT != '0)) ? S_INT1 : S_FETCH;

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: begin
        case (opcode)
          4'h1: state_nx = S_LDI;
          4'h2: state_nx = S_LD;
          4'h3: state_nx = S_ST;
          4'h4: state_nx = S_JZ;
          4'h5: state_nx = S_JMP;
          4'h7: state_nx = S_ALU;
          4'h8: state_nx = S_PUSH;
          4'h9: state_nx = S_POP1;
          4'hA: state_nx = S_CALL;
          4'hB: state_nx = S_RET1;
          4'hC: state_nx = S_STI;
          4'hD: state_nx = S_CLI;
          4'hE: state_nx = S_IRET1;
          default: state_nx = S_NOP;
        endcase
      end
      S_NOP, S_LDI, S_LD, S_ST, S_JMP, S_ALU, S_PUSH,
      S_POP2, S_CALL, S_RET2, S_STI, S_IRET3: state_nx = done_nx;
      S_JZ:    state_nx = zf ? S_JMP : done_nx;
      S_POP1:  state_nx = S_POP2;
      S_RET1:  state_nx = S_RET2;
      S_IRET1: state_nx = S_IRET2;
      S_IRET2: state_nx = S_IRET3;
      S_INT1:  state_nx = S_INT2;
      S_INT2:  state_nx = S_INT3;
      S_INT3:  state_nx = S_FETCH;
      S_CLI:   state_nx = S_FETCH;
      default: state_nx = S_FETCH;
    endcase
  end

  // Outputs depend only on held state, so a mem_rdy stall holds them too.
  always_comb begin
    address  = pc;
    data_out = b_val;
    memwt    = 1'b0;
    intack   = '0;
    case (state)
      S_LD:    address = a_val[AW-1:0];
      S_ST:    begin address = a_val[AW-1:0]; memwt = 1'b1; end
      S_PUSH:  begin address = sp[AW-1:0]; memwt = 1'b1; end
      S_CALL, S_INT1: begin
        address  = sp[AW-1:0];
        data_out = DW'(pc);
        memwt    = 1'b1;
      end
      S_INT2: begin
        address  = sp[AW-1:0];
        data_out = DW'(zf);
        memwt    = 1'b1;
        intack   = NINT'(1) << chan;
      end
      S_POP2, S_RET2, S_IRET2, S_IRET3: address = sp[AW-1:0];
      S_INT3:  address = VEC_BASE + AW'(chan);
      default: ;
    endcase
    if (rst) begin
      address  = '0;
      data_out = '0;
      memwt    = 1'b0;
      intack   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      zf    <= 1'b0;
      ief   <= 1'b0;
      chan  <= '0;
      for (int i = 0; i < 7; i++) regs[i] <= '0;
      regs[7] <= DW'(SP_INIT);
    end else if (mem_rdy) begin
      state <= state_nx;
      case (state)
        S_FETCH: begin ir <= data_in[DW-5:0]; pc <= pc + ONE_A; end
        S_LDI:   begin regs[f_d] <= data_in; pc <= pc + ONE_A; end
        S_LD:    regs[f_d] <= data_in;
        S_JMP:   pc <= pc + ir[AW-1:0];
        S_ALU:   begin regs[f_d] <= alu_res; zf <= (alu_res == '0); end
        S_PUSH:  regs[7] <= sp - ONE_D;
        S_CALL:  begin regs[7] <= sp - ONE_D; pc <= pc + ir[AW-1:0]; end
        S_POP1, S_RET1, S_IRET1: regs[7] <= sp + ONE_D;
        S_POP2:  regs[f_d] <= data_in;
        S_RET2:  pc <= data_in[AW-1:0];
        S_STI:   ief <= 1'b1;
        S_CLI:   ief <= 1'b0;
        S_IRET2: begin zf <= data_in[0]; regs[7] <= sp + ONE_D; end
        S_IRET3: begin pc <= data_in[AW-1:0]; ief <= 1'b1; end
        S_INT1: begin
          regs[7] <= sp - ONE_D;
          ief     <= 1'b0;
          chan    <= int_chan;
        end
        S_INT2:  regs[7] <= sp - ONE_D;
        S_INT3:  pc <= data_in[AW-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_pv.sv
// Directed program bench for cpu_pv: behavioural memory, hand-computed
// register/stack/interrupt expectations.
module tb_cpu_pv;
  localparam int DW = 16, AW = 12, NINT = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mem_rdy = 1'b1;
  logic [DW-1:0]   data_in, data_out;
  logic [AW-1:0]   address;
  logic            memwt;
  logic [NINT-1:0] int_req = '0;
  logic [NINT-1:0] intack;

  logic [DW-1:0]   mem [4096];
  int              wr_cnt = 0;
  int              n_chk = 0, n_pass = 0;
  int              wc0;

  cpu_pv dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
    .address(address), .memwt(memwt), .mem_rdy(mem_rdy),
    .INT(int_req), .intack(intack)
  );

  always #5 clk = ~clk;

  assign data_in = mem[address];

  always @(posedge clk)
    if (!rst && mem_rdy && memwt) begin
      mem[address] <= data_out;
      wr_cnt <= wr_cnt + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ins(input int op, f, b, a, d);
    return 16'((op << 12) | (f << 9) | (b << 6) | (a << 3) | d);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    // branch test
    mem[0]  = ins(1,0,0,0,1); mem[1]  = 16'd5;
    mem[2]  = ins(1,0,0,0,2); mem[3]  = 16'd5;
    mem[4]  = ins(7,1,2,1,3);              // r3 = r1 - r2
    mem[5]  = 16'h4002;                    // JZ +2
    mem[6]  = ins(1,0,0,0,5); mem[7] = 16'h00AA;
    // clz
    mem[8]  = ins(1,0,0,0,1); mem[9]  = 16'h8000;
    mem[10] = ins(7,7,4,1,4);
    mem[11] = ins(1,0,0,0,1); mem[12] = 16'h0000;
    mem[13] = ins(7,7,4,1,4);
    // misc ALU
    mem[14] = ins(7,0,4,4,5);              // r5 = r4 + r4
    mem[15] = ins(7,7,2,4,6);              // r6 = r4 + 1
    mem[16] = ins(7,4,4,6,0);              // r0 = r6 ^ r4
    mem[17] = ins(7,5,0,6,2);              // r2 = r6 << r0
    // store / load
    mem[18] = ins(1,0,0,0,1); mem[19] = 16'h0200;
    mem[20] = ins(3,0,6,1,0);              // mem[r1] = r6
    mem[21] = ins(2,0,0,1,3);              // r3 = mem[r1]
    // stack
    mem[22] = ins(8,0,6,0,0);              // PUSH r6
    mem[23] = ins(9,0,0,0,0);              // POP r0
    mem[24] = 16'hA005;                    // CALL +5 -> 30
    mem[30] = 16'hB000;                    // RET
    // interrupt
    mem[25] = ins(7,7,0,6,5);              // r5 = (r6==0) -> zf=1
    mem[26] = 16'hC000;                    // STI
    mem[27] = 16'h0000;                    // NOP
    mem[28] = 16'hE000;                    // IRET (reset-abort test)
    mem[12'h7F1] = 16'h0040;
    mem[12'h040] = ins(7,7,2,5,5);         // r5 = r5 + 1 -> zf=0
    mem[12'h041] = 16'hE000;

    step(2);
    chk("rst_addr", 32'(address), 0);
    chk("rst_memwt", 32'(memwt), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_intack", 32'(intack), 0);
    chk("rst_sp", 32'(dut.regs[7]), 32'h0FFF);
    rst = 1'b0;

    step(9);
    chk("sub_r3", 32'(dut.regs[3]), 0);
    chk("sub_zf", 32'(dut.zf), 1);
    chk("jz_pc", 32'(dut.pc), 8);

    step(4);
    chk("clz8000", 32'(dut.regs[4]), 0);
    step(4);
    chk("clz0", 32'(dut.regs[4]), 16);
    chk("clz0_zf", 32'(dut.zf), 0);

    step(8);
    chk("add_r5", 32'(dut.regs[5]), 32);
    chk("inc_r6", 32'(dut.regs[6]), 17);
    chk("xor_r0", 32'(dut.regs[0]), 1);
    chk("shl_r2", 32'(dut.regs[2]), 34);

    step(6);
    chk("st_mem", 32'(mem[12'h200]), 17);
    chk("ld_r3", 32'(dut.regs[3]), 17);

    step(1);                               // now in PUSH
    mem_rdy = 1'b0;
    wc0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      chk("stall_memwt", 32'(memwt), 1);
      chk("stall_addr", 32'(address), 32'hFFF);
      step(1);
    end
    chk("stall_sp", 32'(dut.regs[7]), 32'h0FFF);
    chk("stall_nowr", 32'(wr_cnt), 32'(wc0));
    mem_rdy = 1'b1;
    step(1);
    chk("push_onewr", 32'(wr_cnt), 32'(wc0 + 1));
    chk("push_sp", 32'(dut.regs[7]), 32'h0FFE);
    chk("push_mem", 32'(mem[12'hFFF]), 17);

    step(3);
    chk("pop_r0", 32'(dut.regs[0]), 17);
    chk("pop_sp", 32'(dut.regs[7]), 32'h0FFF);

    step(5);
    chk("call_mem", 32'(mem[12'hFFF]), 25);
    chk("ret_pc", 32'(dut.pc), 25);
    chk("ret_sp", 32'(dut.regs[7]), 32'h0FFF);

    int_req = 4'b0110;
    step(4);                               // ALU, STI done
    chk("sti_nointr", 32'(dut.state), 0);
    chk("sti_ief", 32'(dut.ief), 1);
    step(2);                               // NOP done -> INT1
    chk("int1_addr", 32'(address), 32'hFFF);
    chk("int1_dout", 32'(data_out), 28);
    chk("int1_memwt", 32'(memwt), 1);
    chk("int1_intack", 32'(intack), 0);
    step(1);
    chk("int2_addr", 32'(address), 32'hFFE);
    chk("int2_dout", 32'(data_out), 1);
    chk("int2_intack", 32'(intack), 32'b0010);
    chk("int2_ief", 32'(dut.ief), 0);
    step(1);
    chk("int3_addr", 32'(address), 32'h7F1);
    chk("int3_memwt", 32'(memwt), 0);
    chk("int3_intack", 32'(intack), 0);
    chk("int3_sp", 32'(dut.regs[7]), 32'h0FFD);
    step(1);
    chk("isr_pc", 32'(dut.pc), 32'h040);
    chk("stk_pc", 32'(mem[12'hFFF]), 28);
    chk("stk_zf", 32'(mem[12'hFFE]), 1);
    int_req = '0;

    step(2);
    chk("isr_zf", 32'(dut.zf), 0);
    step(4);
    chk("iret_pc", 32'(dut.pc), 28);
    chk("iret_zf", 32'(dut.zf), 1);
    chk("iret_ief", 32'(dut.ief), 1);
    chk("iret_sp", 32'(dut.regs[7]), 32'h0FFF);
    chk("iret_fetch", 32'(address), 28);

    step(2);                               // into IRET2
    chk("in_iret2", 32'(dut.state), 17);
    rst = 1'b1;
    mem_rdy = 1'b0;
    #1;
    chk("rstin_addr", 32'(address), 0);
    chk("rstin_memwt", 32'(memwt), 0);
    step(1);
    chk("abort_pc", 32'(dut.pc), 0);
    chk("abort_sp", 32'(dut.regs[7]), 32'h0FFF);
    chk("abort_ief", 32'(dut.ief), 0);
    chk("abort_state", 32'(dut.state), 0);
    chk("abort_zf", 32'(dut.zf), 0);
    rst = 1'b0;
    mem_rdy = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
